// File: rtl/writeback_queue_if.sv
// Bundle of register-writeback signals: producer handshake, register-file
// write port, two forwarding lookups, and occupancy status.
interface writeback_queue_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                     inValid;
  logic                     inReady;
  logic        [ADDR_W-1:0] inRegister;
  logic signed [DATA_W-1:0] inData;
  logic                     drainEnable;
  logic                     RegWrite;
  logic        [ADDR_W-1:0] writeRegister;
  logic signed [DATA_W-1:0] writeData;
  logic        [ADDR_W-1:0] lookupReg1;
  logic        [ADDR_W-1:0] lookupReg2;
  logic                     fwdHit1;
  logic                     fwdHit2;
  logic signed [DATA_W-1:0] fwdData1;
  logic signed [DATA_W-1:0] fwdData2;
  logic         [CNT_W-1:0] count;
  logic                     empty;

  modport master (
    output inValid, inRegister, inData, drainEnable, lookupReg1, lookupReg2,
    input  inReady, RegWrite, writeRegister, writeData,
           fwdHit1, fwdHit2, fwdData1, fwdData2, count, empty
  );

  modport slave (
    input  inValid, inRegister, inData, drainEnable, lookupReg1, lookupReg2,
    output inReady, RegWrite, writeRegister, writeData,
           fwdHit1, fwdHit2, fwdData1, fwdData2, count, empty
  );
endinterface

// File: rtl/writeback_queue.sv
// FIFO of pending register writes draining into the register-file write port,
// with two youngest-first forwarding lookups over queued and committing writes.
module writeback_queue #(
  parameter int DEPTH    = 4,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31
) (
  input  logic               clk,
  input  logic               reset_n,
  writeback_queue_if.slave   bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic        [ADDR_W-1:0] entry_reg  [DEPTH];
  logic signed [DATA_W-1:0] entry_data [DEPTH];
  logic         [DEPTH-1:0] entry_vld;
  logic         [PTR_W-1:0] head;
  logic         [PTR_W-1:0] tail;
  logic         [CNT_W-1:0] cnt;

  logic                     vld_p1;
  logic        [ADDR_W-1:0] reg_p1;
  logic signed [DATA_W-1:0] data_p1;

  logic accept;
  logic do_write;
  logic do_drain;

  // Ready depends only on registered occupancy; a same-cycle drain never frees a slot early.
  assign bus.inReady = (cnt < CNT_W'(DEPTH));
  assign accept      = bus.inValid && bus.inReady;
  assign do_write    = accept && (bus.inRegister != ADDR_W'(ZERO_REG));
  assign do_drain    = bus.drainEnable && (cnt != '0);

  // Stage p0 -> p1: queue bookkeeping and commit register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head          <= '0;
      tail          <= '0;
      cnt           <= '0;
      entry_vld     <= '0;
      vld_p1        <= 1'b0;
      reg_p1        <= '0;
      data_p1       <= '0;
    end else begin
      if (do_write) begin
        entry_vld[tail] <= 1'b1;
        tail            <= tail + PTR_W'(1);
      end
      if (do_drain) begin
        entry_vld[head] <= 1'b0;
        head            <= head + PTR_W'(1);
        vld_p1          <= 1'b1;
        reg_p1          <= entry_reg[head];
        data_p1         <= entry_data[head];
      end else begin
        vld_p1          <= 1'b0;
      end
      case ({do_write, do_drain})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry payload carries no reset; validity is tracked separately.
  always_ff @(posedge clk) begin
    if (do_write) begin
      entry_reg[tail]  <= bus.inRegister;
      entry_data[tail] <= bus.inData;
    end
  end

  // Walks oldest to youngest so the last match (youngest) wins; commit register is oldest.
  function automatic logic [DATA_W:0] fwd_lookup(input logic [ADDR_W-1:0] q);
    logic [DATA_W:0] res;
    logic [PTR_W-1:0] idx;
    res = '0;
    if (q != ADDR_W'(ZERO_REG)) begin
      if (vld_p1 && (reg_p1 == q)) res = {1'b1, data_p1};
      for (int k = 0; k < DEPTH; k++) begin
        idx = head + PTR_W'(k);
        if (entry_vld[idx] && (entry_reg[idx] == q)) res = {1'b1, entry_data[idx]};
      end
    end
    return res;
  endfunction

  assign {bus.fwdHit1, bus.fwdData1} = fwd_lookup(bus.lookupReg1);
  assign {bus.fwdHit2, bus.fwdData2} = fwd_lookup(bus.lookupReg2);

  assign bus.RegWrite      = vld_p1;
  assign bus.writeRegister = reg_p1;
  assign bus.writeData     = data_p1;
  assign bus.count         = cnt;
  assign bus.empty         = (cnt == '0);
endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: reset, commit latency, fill/full,
// drain with wrap, zero-register drop, forwarding priority, mid-run reset.
module tb_writeback_queue;
  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  writeback_queue_if #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) bus ();

  writeback_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(5), .ZERO_REG(31)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.inValid = 1'b0; bus.inRegister = '0; bus.inData = '0;
    bus.drainEnable = 1'b0; bus.lookupReg1 = '0; bus.lookupReg2 = '0;
    tick(); tick();
    reset_n = 1'b1;
    #1;
    total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", bus.count); end
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", bus.empty); end
    total++; if (bus.RegWrite !== 1'b0) begin bad++; $display("FAIL reset_regwrite got=%b want=0", bus.RegWrite); end
    total++; if (bus.writeRegister !== 5'd0) begin bad++; $display("FAIL reset_wreg got=%0d want=0", bus.writeRegister); end
    total++; if (bus.writeData !== 32'd0) begin bad++; $display("FAIL reset_wdata got=%h want=0", bus.writeData); end
    total++; if (bus.inReady !== 1'b1) begin bad++; $display("FAIL reset_inready got=%b want=1", bus.inReady); end
  endtask

  task automatic test_single();
    bus.inValid = 1'b1; bus.inRegister = 5'd3; bus.inData = 32'h11; bus.drainEnable = 1'b1;
    tick();
    bus.inValid = 1'b0;
    total++; if (bus.RegWrite !== 1'b0) begin bad++; $display("FAIL single_no_same_cycle got=%b want=0", bus.RegWrite); end
    total++; if (bus.count !== 3'd1) begin bad++; $display("FAIL single_count1 got=%0d want=1", bus.count); end
    tick();
    total++; if (bus.RegWrite !== 1'b1) begin bad++; $display("FAIL single_regwrite got=%b want=1", bus.RegWrite); end
    total++; if (bus.writeRegister !== 5'd3) begin bad++; $display("FAIL single_wreg got=%0d want=3", bus.writeRegister); end
    total++; if (bus.writeData !== 32'h11) begin bad++; $display("FAIL single_wdata got=%h want=11", bus.writeData); end
    tick();
    total++; if (bus.RegWrite !== 1'b0) begin bad++; $display("FAIL single_regwrite_off got=%b want=0", bus.RegWrite); end
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL single_empty got=%b want=1", bus.empty); end
    bus.drainEnable = 1'b0;
  endtask

  task automatic test_fill();
    logic [4:0]  fr [4] = '{5'd1, 5'd2, 5'd1, 5'd4};
    logic [31:0] fd [4] = '{32'd5, 32'd6, 32'd7, 32'd8};
    bus.drainEnable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.inValid = 1'b1; bus.inRegister = fr[i]; bus.inData = fd[i];
      tick();
    end
    bus.inRegister = 5'd9; bus.inData = 32'hFFFF_FFFF;
    total++; if (bus.count !== 3'd4) begin bad++; $display("FAIL fill_count got=%0d want=4", bus.count); end
    total++; if (bus.inReady !== 1'b0) begin bad++; $display("FAIL fill_inready got=%b want=0", bus.inReady); end
    tick();
    bus.inValid = 1'b0;
    total++; if (bus.count !== 3'd4) begin bad++; $display("FAIL fill_reject got=%0d want=4", bus.count); end
    bus.lookupReg1 = 5'd1; bus.lookupReg2 = 5'd4;
    #1;
    total++; if (bus.fwdHit1 !== 1'b1) begin bad++; $display("FAIL fill_hit1 got=%b want=1", bus.fwdHit1); end
    total++; if (bus.fwdData1 !== 32'd7) begin bad++; $display("FAIL fill_data1 got=%h want=7", bus.fwdData1); end
    total++; if (bus.fwdData2 !== 32'd8) begin bad++; $display("FAIL fill_data2 got=%h want=8", bus.fwdData2); end
    bus.lookupReg1 = 5'd7; bus.lookupReg2 = 5'd2;
    #1;
    total++; if (bus.fwdHit1 !== 1'b0 || bus.fwdData1 !== 32'd0) begin bad++; $display("FAIL fill_miss got=%b/%h want=0/0", bus.fwdHit1, bus.fwdData1); end
    total++; if (bus.fwdData2 !== 32'd6) begin bad++; $display("FAIL fill_data2_r2 got=%h want=6", bus.fwdData2); end
  endtask

  task automatic test_drain_wrap();
    logic [4:0]  er [7] = '{5'd1, 5'd2, 5'd1, 5'd4, 5'd9, 5'd9, 5'd9};
    logic [31:0] ed [7] = '{32'd5, 32'd6, 32'd7, 32'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [2:0]  ec [7] = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
    bus.drainEnable = 1'b1;
    bus.inValid = 1'b1; bus.inRegister = 5'd9; bus.inData = 32'hFFFF_FFFF;
    for (int i = 0; i < 7; i++) begin
      if (i == 4) bus.inValid = 1'b0;
      tick();
      total++; if (bus.RegWrite !== 1'b1 || bus.writeRegister !== er[i] || bus.writeData !== ed[i]) begin
        bad++; $display("FAIL drain_commit%0d got=%b r%0d %h want=1 r%0d %h", i, bus.RegWrite, bus.writeRegister, bus.writeData, er[i], ed[i]);
      end
      total++; if (bus.count !== ec[i]) begin bad++; $display("FAIL drain_count%0d got=%0d want=%0d", i, bus.count, ec[i]); end
    end
    tick();
    total++; if (bus.RegWrite !== 1'b0 || bus.empty !== 1'b1) begin bad++; $display("FAIL drain_end got=%b/%b want=0/1", bus.RegWrite, bus.empty); end
    total++; if (bus.writeRegister !== 5'd9) begin bad++; $display("FAIL drain_hold got=%0d want=9", bus.writeRegister); end
    bus.drainEnable = 1'b0;
  endtask

  task automatic test_zero_reg();
    bus.drainEnable = 1'b1;
    bus.inValid = 1'b1; bus.inRegister = 5'd31; bus.inData = 32'h1234;
    #1;
    total++; if (bus.inReady !== 1'b1) begin bad++; $display("FAIL zero_ready got=%b want=1", bus.inReady); end
    tick();
    bus.inValid = 1'b0;
    total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL zero_count got=%0d want=0", bus.count); end
    tick();
    total++; if (bus.RegWrite !== 1'b0) begin bad++; $display("FAIL zero_regwrite got=%b want=0", bus.RegWrite); end
    bus.lookupReg1 = 5'd31;
    #1;
    total++; if (bus.fwdHit1 !== 1'b0 || bus.fwdData1 !== 32'd0) begin bad++; $display("FAIL zero_fwd got=%b/%h want=0/0", bus.fwdHit1, bus.fwdData1); end
    bus.drainEnable = 1'b0;
  endtask

  task automatic test_forward_commit();
    bus.drainEnable = 1'b0;
    bus.inValid = 1'b1; bus.inRegister = 5'd5; bus.inData = 32'hA;
    bus.lookupReg1 = 5'd5; bus.lookupReg2 = 5'd5;
    #1;
    total++; if (bus.fwdHit1 !== 1'b0) begin bad++; $display("FAIL fwd_inflight got=%b want=0", bus.fwdHit1); end
    tick();
    bus.inValid = 1'b0; bus.drainEnable = 1'b1;
    tick();
    bus.drainEnable = 1'b0;
    #1;
    total++; if (bus.fwdHit1 !== 1'b1 || bus.fwdData1 !== 32'hA) begin bad++; $display("FAIL fwd_commit got=%b/%h want=1/a", bus.fwdHit1, bus.fwdData1); end
    tick();
    total++; if (bus.fwdHit1 !== 1'b0 || bus.fwdData1 !== 32'd0) begin bad++; $display("FAIL fwd_after got=%b/%h want=0/0", bus.fwdHit1, bus.fwdData1); end
    bus.inValid = 1'b1; bus.inData = 32'hA;
    tick();
    bus.inData = 32'hB;
    tick();
    bus.inValid = 1'b0; bus.drainEnable = 1'b1;
    tick();
    bus.drainEnable = 1'b0;
    #1;
    total++; if (bus.RegWrite !== 1'b1 || bus.writeData !== 32'hA) begin bad++; $display("FAIL fwd_young_commit got=%b/%h want=1/a", bus.RegWrite, bus.writeData); end
    total++; if (bus.fwdHit1 !== 1'b1 || bus.fwdData1 !== 32'hB) begin bad++; $display("FAIL fwd_young1 got=%b/%h want=1/b", bus.fwdHit1, bus.fwdData1); end
    total++; if (bus.fwdHit2 !== 1'b1 || bus.fwdData2 !== 32'hB) begin bad++; $display("FAIL fwd_young2 got=%b/%h want=1/b", bus.fwdHit2, bus.fwdData2); end
    bus.drainEnable = 1'b1;
    tick();
    bus.drainEnable = 1'b0;
    tick();
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL fwd_empty got=%b want=1", bus.empty); end
  endtask

  task automatic test_reset_mid();
    bus.drainEnable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.inValid = 1'b1; bus.inRegister = 5'(6 + i); bus.inData = 32'(100 + i);
      tick();
    end
    bus.inValid = 1'b0;
    bus.lookupReg1 = 5'd6; bus.lookupReg2 = 5'd8;
    #1;
    total++; if (bus.count !== 3'd3) begin bad++; $display("FAIL mid_count3 got=%0d want=3", bus.count); end
    total++; if (bus.fwdData2 !== 32'd102) begin bad++; $display("FAIL mid_fwd_pre got=%h want=66", bus.fwdData2); end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    #1;
    total++; if (bus.count !== 3'd0 || bus.RegWrite !== 1'b0) begin bad++; $display("FAIL mid_reset got=%0d/%b want=0/0", bus.count, bus.RegWrite); end
    total++; if (bus.fwdHit1 !== 1'b0 || bus.fwdHit2 !== 1'b0) begin bad++; $display("FAIL mid_fwd got=%b/%b want=0/0", bus.fwdHit1, bus.fwdHit2); end
    bus.drainEnable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (bus.RegWrite !== 1'b0) begin bad++; $display("FAIL mid_stale%0d got=%b want=0", i, bus.RegWrite); end
    end
    bus.drainEnable = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single();
    test_fill();
    test_drain_wrap();
    test_zero_reg();
    test_forward_commit();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
